// File: rtl/move_scheduler.sv
// rtl/move_scheduler.sv - arbitrates manual moves against LFSR shuffle bursts, issues one move at a time
// over valid/ready, counts player steps and locks play once the board is solved.
module move_scheduler #(
    parameter int          SHUFFLE_LEN = 32,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int          STEP_MAX    = 999
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_btn_dir,
    input  logic       i_shuffle_req,
    input  logic       i_game_done,
    input  logic       i_move_ready,
    output logic       o_move_valid,
    output logic [1:0] o_move_dir,
    output logic       o_busy,
    output logic       o_shuffling,
    output logic       o_locked,
    output logic [9:0] o_step_count
);

    localparam logic [1:0]  S_IDLE      = 2'd0;
    localparam logic [1:0]  S_MAN_ISSUE = 2'd1;
    localparam logic [1:0]  S_SHUF      = 2'd2;
    localparam logic [1:0]  S_DONE_LOCK = 2'd3;
    localparam logic [15:0] LFSR_TAPS   = 16'hB400;
    localparam logic [7:0]  SHUF_LEN8   = 8'(SHUFFLE_LEN);
    localparam logic [9:0]  STEP_MAX10  = 10'(STEP_MAX);

    logic [1:0]  r_state;
    logic [15:0] r_lfsr;
    logic        r_shuf_q;
    logic [7:0]  r_remaining;
    logic        r_move_valid;
    logic [1:0]  r_move_dir;
    logic [9:0]  r_step;

    logic        w_shuf_edge;
    logic        w_xfer;
    logic [15:0] w_lfsr_next;
    logic [1:0]  w_btn_idx;
    logic [1:0]  w_cand;
    logic [1:0]  w_shuf_next_dir;
    logic        w_start_burst;

    assign w_shuf_edge = i_shuffle_req & ~r_shuf_q;
    assign w_xfer      = r_move_valid & i_move_ready;
    assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_TAPS) : (r_lfsr >> 1);
    assign w_cand      = r_lfsr[1:0];

    // The move being transferred becomes the "last" move, so the inverse check runs against it directly.
    assign w_shuf_next_dir = (w_cand == (r_move_dir ^ 2'b01)) ? (w_cand ^ 2'b10) : w_cand;

    assign w_start_burst = w_shuf_edge && ((r_state == S_IDLE) || (r_state == S_DONE_LOCK));

    always_comb begin
        w_btn_idx = 2'd0;
        casez (i_btn_dir)
            4'b???1: w_btn_idx = 2'd0;
            4'b??10: w_btn_idx = 2'd1;
            4'b?100: w_btn_idx = 2'd2;
            4'b1000: w_btn_idx = 2'd3;
            default: w_btn_idx = 2'd0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= S_IDLE;
            r_lfsr       <= LFSR_SEED;
            r_shuf_q     <= i_shuffle_req;
            r_remaining  <= 8'd0;
            r_move_valid <= 1'b0;
            r_move_dir   <= 2'd0;
            r_step       <= 10'd0;
        end else begin
            r_lfsr   <= w_lfsr_next;
            r_shuf_q <= i_shuffle_req;
            if (w_start_burst) begin
                r_state      <= S_SHUF;
                r_remaining  <= SHUF_LEN8;
                r_step       <= 10'd0;
                r_move_dir   <= w_cand;
                r_move_valid <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_btn_dir != 4'd0) begin
                            r_state      <= S_MAN_ISSUE;
                            r_move_dir   <= w_btn_idx;
                            r_move_valid <= 1'b1;
                        end else if (i_game_done) begin
                            r_state <= S_DONE_LOCK;
                        end
                    end
                    S_MAN_ISSUE: begin
                        if (w_xfer) begin
                            r_state      <= S_IDLE;
                            r_move_valid <= 1'b0;
                            if (r_step < STEP_MAX10) begin
                                r_step <= r_step + 10'd1;
                            end
                        end
                    end
                    S_SHUF: begin
                        if (w_xfer) begin
                            if (r_remaining <= 8'd1) begin
                                r_state      <= S_IDLE;
                                r_move_valid <= 1'b0;
                                r_remaining  <= 8'd0;
                            end else begin
                                r_remaining <= r_remaining - 8'd1;
                                r_move_dir  <= w_shuf_next_dir;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign o_move_valid = r_move_valid;
    assign o_move_dir   = r_move_dir;
    assign o_busy       = (r_state == S_MAN_ISSUE) || (r_state == S_SHUF);
    assign o_shuffling  = (r_state == S_SHUF);
    assign o_locked     = (r_state == S_DONE_LOCK);
    assign o_step_count = r_step;

endmodule

// File: tb/tb_move_scheduler.sv
// tb/tb_move_scheduler.sv - self-checking bench for move_scheduler: manual vector table, shuffle bursts,
// lockout and reset-mid-burst sequences with a move scoreboard and LFSR reference.
module tb_move_scheduler;

    logic       clk;
    logic       rst;
    logic [3:0] btn_dir;
    logic       shuffle_req;
    logic       game_done;
    logic       move_ready;
    logic       move_valid;
    logic [1:0] move_dir;
    logic       busy;
    logic       shuffling;
    logic       locked;
    logic [9:0] step_count;

    move_scheduler #(.SHUFFLE_LEN(32), .LFSR_SEED(16'hACE1), .STEP_MAX(999)) dut (
        .i_clk(clk), .i_rst(rst), .i_btn_dir(btn_dir), .i_shuffle_req(shuffle_req),
        .i_game_done(game_done), .i_move_ready(move_ready), .o_move_valid(move_valid),
        .o_move_dir(move_dir), .o_busy(busy), .o_shuffling(shuffling), .o_locked(locked),
        .o_step_count(step_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [1:0] pick(input logic [1:0] c, input logic [1:0] prev);
        return (c == (prev ^ 2'b01)) ? (c ^ 2'b10) : c;
    endfunction

    // Reference LFSR: x^16+x^14+x^13+x^11 in right-shift Galois form.
    logic [15:0] m_lfsr;
    always @(posedge clk or negedge rst) begin
        if (!rst) m_lfsr <= 16'hACE1;
        else      m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end

    logic [1:0] man_q[$];
    int         shuf_xfers;
    int         shuf_cycles;
    logic       pv, pxfer, pshuf, pend, have_last;
    logic [1:0] pdir, pend_dir, last_dir;
    logic [15:0] plfsr;

    always @(negedge clk) begin
        logic xfer;
        if (!rst) begin
            pv = 0; pxfer = 0; pshuf = 0; pend = 0; have_last = 0;
        end else begin
            xfer = move_valid && move_ready;
            if (pv && !pxfer) begin
                chk("hold_valid", int'(move_valid), 1);
                chk("hold_dir", int'(move_dir), int'(pdir));
            end
            if (shuffling && !pshuf) begin
                have_last = 0;
                chk("shuf_first_dir", int'(move_dir), int'(plfsr[1:0]));
            end else if (pend && shuffling && move_valid) begin
                chk("shuf_next_dir", int'(move_dir), int'(pend_dir));
            end
            pend = 0;
            if (shuffling) shuf_cycles++;
            if (xfer) begin
                if (shuffling) begin
                    shuf_xfers++;
                    if (have_last) chk("no_inverse", int'(move_dir != (last_dir ^ 2'b01)), 1);
                    last_dir  = move_dir;
                    have_last = 1;
                    pend_dir  = pick(m_lfsr[1:0], move_dir);
                    pend      = 1;
                end else begin
                    chk("manual_expected", int'(man_q.size() > 0), 1);
                    if (man_q.size() > 0) chk("manual_dir", int'(move_dir), int'(man_q.pop_front()));
                end
            end
            pv = move_valid; pxfer = xfer; pdir = move_dir; pshuf = shuffling; plfsr = m_lfsr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_burst_end(input string name, input logic toggle_ready, input logic poke_btn);
        int n;
        n = 0;
        while (shuffling && n < 200) begin
            if (toggle_ready) move_ready = ~move_ready;
            if (poke_btn && (n % 7 == 3)) btn_dir = 4'b0100;
            tick();
            btn_dir = 4'b0000;
            n++;
        end
        chk({name, "_ended"}, int'(n < 200), 1);
    endtask

    typedef struct {
        logic [3:0] btn;
        int         wait_cyc;
        logic [1:0] dir;
    } man_vec_t;

    man_vec_t vecs[6];
    int exp_step;

    initial begin
        vecs[0] = '{4'b0100, 0, 2'd2};
        vecs[1] = '{4'b1010, 5, 2'd1};
        vecs[2] = '{4'b0001, 1, 2'd0};
        vecs[3] = '{4'b1000, 2, 2'd3};
        vecs[4] = '{4'b1100, 0, 2'd2};
        vecs[5] = '{4'b0011, 3, 2'd0};

        rst = 0; btn_dir = 0; shuffle_req = 0; game_done = 0; move_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", int'(move_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_step", int'(step_count), 0);
        rst = 1;
        tick();
        chk("idle_busy", int'(busy), 0);

        exp_step = 0;
        for (int i = 0; i < 6; i++) begin
            btn_dir = vecs[i].btn;
            man_q.push_back(vecs[i].dir);
            tick();
            btn_dir = 0;
            chk("man_valid", int'(move_valid), 1);
            chk("man_dir_now", int'(move_dir), int'(vecs[i].dir));
            for (int d = 0; d < vecs[i].wait_cyc; d++) begin
                if (d == 1) btn_dir = 4'b0001;
                tick();
                btn_dir = 0;
            end
            move_ready = 1;
            tick();
            move_ready = 0;
            exp_step++;
            chk("man_done_valid", int'(move_valid), 0);
            chk("man_step", int'(step_count), exp_step);
        end

        // Burst with ready held high: 32 back-to-back transfers.
        move_ready = 1; shuffle_req = 1;
        shuf_xfers = 0; shuf_cycles = 0;
        tick();
        chk("burstA_step_clr", int'(step_count), 0);
        chk("burstA_shuffling", int'(shuffling), 1);
        wait_burst_end("burstA", 1'b0, 1'b0);
        #4;
        chk("burstA_xfers", shuf_xfers, 32);
        chk("burstA_cycles", shuf_cycles, 32);
        chk("burstA_busy", int'(busy), 0);
        shuffle_req = 0; move_ready = 0;
        tick();

        // Burst with toggling ready and button noise.
        shuffle_req = 1; shuf_xfers = 0;
        tick();
        wait_burst_end("burstB", 1'b1, 1'b1);
        #4;
        chk("burstB_xfers", shuf_xfers, 32);
        chk("burstB_step", int'(step_count), 0);
        shuffle_req = 0; move_ready = 1;
        tick();

        // Solved board locks out manual play.
        btn_dir = 4'b0001;
        man_q.push_back(2'd0);
        tick();
        btn_dir = 0;
        tick();
        chk("lock_pre_step", int'(step_count), 1);
        game_done = 1;
        tick();
        tick();
        chk("locked", int'(locked), 1);
        btn_dir = 4'b0010;
        tick();
        btn_dir = 0;
        tick();
        chk("lock_no_valid", int'(move_valid), 0);
        chk("lock_step_frozen", int'(step_count), 1);
        game_done = 0;
        tick();
        chk("lock_holds", int'(locked), 1);
        shuffle_req = 1; shuf_xfers = 0;
        tick();
        chk("unlock", int'(locked), 0);
        chk("unlock_shuffling", int'(shuffling), 1);
        wait_burst_end("burstC", 1'b0, 1'b0);
        #4;
        chk("burstC_xfers", shuf_xfers, 32);
        shuffle_req = 0;
        tick();

        // Shuffle edge beats a same-cycle button; reset mid-burst.
        shuffle_req = 1; btn_dir = 4'b0001; shuf_xfers = 0;
        tick();
        btn_dir = 0;
        chk("prio_shuffling", int'(shuffling), 1);
        begin
            int n;
            n = 0;
            while (shuf_xfers < 10 && n < 100) begin
                tick();
                n++;
            end
            chk("reach_xfer10", shuf_xfers, 10);
        end
        rst = 0;
        #1;
        chk("rst_mid_valid", int'(move_valid), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_shuf", int'(shuffling), 0);
        chk("rst_mid_dir", int'(move_dir), 0);
        tick();
        rst = 1;
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 20; k++) begin
                tick();
                if (move_valid || busy) seen++;
            end
            chk("no_resume", seen, 0);
        end
        chk("man_q_empty", man_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
